// File: rtl/fifo_pkg.sv
// Shared definitions for the threshold-release stream FIFO: pointer width helper
// and the eot-split view of a stream word.
package fifo_pkg;

    localparam int WORD_W = 16;

    typedef struct packed {
        logic              eot;
        logic [WORD_W-2:0] data;
    } word_t;

    // Pointers carry one extra wrap bit so that a full FIFO is distinguishable from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready stream bundle; the producer drives data/valid, the consumer drives ready.
interface dti #(
    parameter int W = 16
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram #(
    parameter int DEPTH = 64,
    parameter int DIN   = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DIN-1:0]           i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DIN-1:0]           o_rdata
);
    logic [DIN-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dti_fifo_thr.sv
// Stream FIFO that holds words back until a fill threshold is reached or an
// end-of-transfer word is stored, with an optional registered output stage.
module dti_fifo_thr
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int DIN       = 16,
    parameter int THRESHOLD = 0,
    parameter int AFULL     = DEPTH - 2,
    parameter int REGOUT    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    dti.consumer                   din,
    dti.producer                   dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW - 1;
    localparam logic [CW:0] PTR_ONE = {{CW{1'b0}}, 1'b1};

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dti_fifo_thr: DEPTH must be a power of two and at least 2");
    end
    if ((THRESHOLD < 0) || (THRESHOLD > DEPTH)) begin : g_bad_thr
        $error("dti_fifo_thr: THRESHOLD must lie in 0..DEPTH");
    end
    if ((AFULL < 1) || (AFULL > DEPTH)) begin : g_bad_afull
        $error("dti_fifo_thr: AFULL must lie in 1..DEPTH");
    end

    logic [CW:0]    r_wptr;
    logic [CW:0]    r_rptr;
    logic [CW:0]    r_eot_cnt;
    logic [CW:0]    w_level;
    logic           w_empty;
    logic           w_full;
    logic           w_thr_ok;
    logic           w_release;
    logic           w_wr;
    logic           w_rd;
    logic           w_wr_eot;
    logic           w_rd_eot;
    logic [DIN-1:0] w_head;

    assign w_level   = r_wptr - r_rptr;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == PW'(DEPTH));
    assign w_thr_ok  = (THRESHOLD == 0) || (w_level >= PW'(THRESHOLD)) || (r_eot_cnt != '0);
    assign w_release = !w_empty && w_thr_ok;

    assign din.ready = !w_full;
    assign w_wr      = din.valid && !w_full;
    assign w_wr_eot  = w_wr && din.data[DIN-1];
    assign w_rd_eot  = w_rd && w_head[DIN-1];

    assign level       = w_level;
    assign almost_full = (w_level >= PW'(AFULL));

    fifo_ram #(
        .DEPTH (DEPTH),
        .DIN   (DIN)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr[CW-1:0]),
        .i_wdata (din.data),
        .i_raddr (r_rptr[CW-1:0]),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_eot_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_wr_eot, w_rd_eot})
                2'b10:   r_eot_cnt <= r_eot_cnt + PTR_ONE;
                2'b01:   r_eot_cnt <= r_eot_cnt - PTR_ONE;
                default: r_eot_cnt <= r_eot_cnt;
            endcase
        end
    end

    if (REGOUT == 0) begin : g_direct
        assign w_rd       = w_release && dout.ready;
        assign dout.valid = w_release;
        assign dout.data  = w_head;
    end else begin : g_regout
        logic           r_ovalid;
        logic [DIN-1:0] r_odata;
        logic           w_load;

        // The stage refills only when empty or being emptied, so a stalled word stays put.
        assign w_load = !r_ovalid || dout.ready;
        assign w_rd   = w_release && w_load;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ovalid <= 1'b0;
                r_odata  <= '0;
            end else if (w_load) begin
                r_ovalid <= w_release;
                r_odata  <= w_head;
            end
        end

        assign dout.valid = r_ovalid;
        assign dout.data  = r_odata;
    end
endmodule

// File: tb/tb_dti_fifo_thr.sv
// Three FIFO configurations driven side by side against a queue-based reference model
// with a scoreboard that pops expected words on every output handshake.
module tb_dti_fifo_thr;
    import fifo_pkg::*;

    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [2:0]       s_valid;
    logic [2:0][15:0] s_data;
    logic [2:0]       s_ready;
    logic [2:0][3:0]  o_level;
    logic [2:0]       o_af;
    logic [2:0]       o_rdy;
    logic [2:0]       o_valid;
    logic [2:0][15:0] o_data;
    int               sb_cnt [3];

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[inst%0d] @%0t: got %0h, expected %0h", nm, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int T = (g == 1) ? 4 : 0;
        localparam int R = (g == 2) ? 1 : 0;

        dti #(.W(16)) din_if ();
        dti #(.W(16)) dout_if ();

        assign din_if.valid  = s_valid[g];
        assign din_if.data   = s_data[g];
        assign dout_if.ready = s_ready[g];
        assign o_rdy[g]      = din_if.ready;
        assign o_valid[g]    = dout_if.valid;
        assign o_data[g]     = dout_if.data;

        dti_fifo_thr #(
            .DEPTH     (D),
            .DIN       (16),
            .THRESHOLD (T),
            .REGOUT    (R)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .din         (din_if),
            .dout        (dout_if),
            .level       (o_level[g]),
            .almost_full (o_af[g])
        );

        // Reference model: sq = words in storage, xq = words accepted but not yet delivered.
        logic [15:0] sq [$];
        logic [15:0] xq [$];
        bit          m_ov;
        logic [15:0] m_od;
        bit          m_r, m_acc, m_rd, m_ld, mv;
        logic [15:0] md, got;

        function automatic bit m_rel();
            if (sq.size() == 0) return 1'b0;
            if (T == 0 || sq.size() >= T) return 1'b1;
            foreach (sq[i]) if (sq[i][15]) return 1'b1;
            return 1'b0;
        endfunction

        initial begin
            m_ov = 1'b0;
            m_od = '0;
        end

        always @(posedge clk) begin
            if (rst) begin
                sq.delete();
                xq.delete();
                m_ov = 1'b0;
                m_od = '0;
            end else begin
                m_r   = m_rel();
                m_acc = s_valid[g] && (sq.size() != D);
                if (R == 0) begin
                    m_rd = m_r && s_ready[g];
                end else begin
                    m_ld = !m_ov || s_ready[g];
                    m_rd = m_r && m_ld;
                    if (m_ld) begin
                        m_ov = m_r;
                        if (m_r) m_od = sq[0];
                    end
                end
                if (m_rd) void'(sq.pop_front());
                if (m_acc) begin
                    sq.push_back(s_data[g]);
                    xq.push_back(s_data[g]);
                end
            end
            sb_cnt[g] = xq.size();
        end

        always @(negedge clk) begin
            if (chk_en) begin
                if (R == 0) begin
                    mv = m_rel();
                    md = mv ? sq[0] : 16'h0;
                end else begin
                    mv = m_ov;
                    md = m_od;
                end
                chk("level", g, 32'(o_level[g]), sq.size());
                chk("almost_full", g, 32'(o_af[g]), 32'(sq.size() >= D - 2));
                chk("din_ready", g, 32'(o_rdy[g]), 32'(sq.size() != D));
                chk("dout_valid", g, 32'(o_valid[g]), 32'(mv));
                if (mv) chk("dout_data", g, 32'(o_data[g]), 32'(md));
                if (!rst && o_valid[g] && s_ready[g]) begin
                    if (xq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_spurious[inst%0d] @%0t: got word %0h, expected none", g, $time, o_data[g]);
                    end else begin
                        got = xq.pop_front();
                        chk("sb_data", g, 32'(o_data[g]), 32'(got));
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [15:0] d, input logic r);
        for (int k = 0; k < 3; k++) begin
            s_valid[k] = v;
            s_data[k]  = d;
            s_ready[k] = r;
        end
    endtask

    function automatic logic [15:0] mkw(input logic eot);
        word_t w;
        w.eot  = eot;
        w.data = 15'($urandom);
        return w;
    endfunction

    task automatic fill(input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            drv(1'b1, mkw(i >= 7), r);
            cyc();
        end
        drv(1'b0, 16'h0, r);
    endtask

    task automatic drain(input int n);
        drv(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        drv(1'b0, 16'h0, 1'b0);
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_level", k, 32'(o_level[k]), 0);
            chk("rst_din_ready", k, 32'(o_rdy[k]), 1);
            chk("rst_dout_valid", k, 32'(o_valid[k]), 0);
            chk("rst_afull", k, 32'(o_af[k]), 0);
        end

        // Fill to full with the sink stalled, then drain in order.
        fill(8, 1'b0);
        chk("full_level", 0, 32'(o_level[0]), 8);
        chk("full_din_ready", 0, 32'(o_rdy[0]), 0);
        chk("full_afull", 0, 32'(o_af[0]), 1);
        drain(12);
        for (int k = 0; k < 3; k++) chk("drained_level", k, 32'(o_level[k]), 0);

        // Short burst ending in eot drains below threshold.
        drv(1'b1, mkw(1'b0), 1'b1);
        cyc();
        chk("eot_w0_valid", 1, 32'(o_valid[1]), 0);
        drv(1'b1, mkw(1'b1), 1'b1);
        cyc();
        chk("eot_w1_valid", 1, 32'(o_valid[1]), 1);
        drv(1'b0, 16'h0, 1'b1);
        cyc();
        chk("eot_mid_level", 1, 32'(o_level[1]), 1);
        cyc();
        chk("eot_end_level", 1, 32'(o_level[1]), 0);

        // Three words without eot stay below threshold; the fourth releases.
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, mkw(1'b0), 1'b1);
            cyc();
        end
        drv(1'b0, 16'h0, 1'b1);
        chk("thr3_valid", 1, 32'(o_valid[1]), 0);
        cyc();
        chk("thr3_valid_hold", 1, 32'(o_valid[1]), 0);
        chk("thr3_level", 1, 32'(o_level[1]), 3);
        drv(1'b1, mkw(1'b0), 1'b1);
        cyc();
        chk("thr4_valid", 1, 32'(o_valid[1]), 1);
        drain(2);
        drv(1'b1, mkw(1'b1), 1'b1);
        cyc();
        drain(10);
        chk("thr_flush_level", 1, 32'(o_level[1]), 0);

        // Simultaneous write and read at full, then at empty.
        fill(8, 1'b0);
        chk("full_rd_din_ready", 0, 32'(o_rdy[0]), 0);
        drv(1'b1, mkw(1'b1), 1'b1);
        cyc();
        chk("full_rd_level", 0, 32'(o_level[0]), 7);
        drain(12);
        chk("full_rd_drained", 0, 32'(o_level[0]), 0);
        drv(1'b1, mkw(1'b1), 1'b1);
        cyc();
        chk("empty_wr_level", 0, 32'(o_level[0]), 1);
        chk("empty_wr_valid", 0, 32'(o_valid[0]), 1);
        drain(4);

        // Registered output, full, sink toggling every cycle.
        fill(9, 1'b0);
        chk("regout_full_level", 2, 32'(o_level[2]), 8);
        chk("regout_full_ready", 2, 32'(o_rdy[2]), 0);
        for (int i = 0; i < 30; i++) begin
            drv(1'b0, 16'h0, logic'(i % 2 == 0));
            cyc();
        end
        chk("regout_toggle_level", 2, 32'(o_level[2]), 0);
        chk("regout_toggle_valid", 2, 32'(o_valid[2]), 0);
        drain(12);

        // Randomized traffic per instance.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                s_valid[k] = ($urandom_range(0, 9) < 6);
                s_data[k]  = mkw($urandom_range(0, 3) == 0);
                s_ready[k] = ($urandom_range(0, 9) < 6);
            end
            cyc();
        end
        drain(12);
        drv(1'b1, mkw(1'b1), 1'b1);
        cyc();
        drain(14);
        for (int k = 0; k < 3; k++) begin
            chk("final_level", k, 32'(o_level[k]), 0);
            chk("sb_outstanding", k, 32'(sb_cnt[k]), 0);
        end

        // Reset in the middle of a transfer.
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, mkw(1'b0), 1'b0);
            cyc();
        end
        drv(1'b0, 16'h0, 1'b0);
        chk("pre_rst_level", 0, 32'(o_level[0]), 5);
        chk("pre_rst_valid", 0, 32'(o_valid[0]), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_level", k, 32'(o_level[k]), 0);
            chk("mid_rst_valid", k, 32'(o_valid[k]), 0);
            chk("mid_rst_din_ready", k, 32'(o_rdy[k]), 1);
        end
        drain(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dti_fifo_thr.md
DTI_FIFO_THR -- requirements
Module: dti_fifo_thr

Interface
REQ-001 SHALL have parameter DEPTH, default 64, storage depth in words; power of two, >= 2.
REQ-002 SHALL have parameter DIN, default 16, word width; bit DIN-1 is eot, bits DIN-2:0 are payload.
REQ-003 SHALL have parameter THRESHOLD, default 0, release level; 0 means release whenever non-empty; legal range 0..DEPTH.
REQ-004 SHALL have parameter AFULL, default DEPTH-2, almost-full level; legal range 1..DEPTH.
REQ-005 SHALL have parameter REGOUT, default 0; 1 inserts one output register stage.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port din  dti.consumer  DIN  input stream (data, valid, ready).
REQ-009 SHALL have port dout  dti.producer  DIN  output stream; the full word, eot bit included, is passed through unchanged.
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  number of words in storage; DEPTH is representable.
REQ-011 SHALL have port almost_full  output  1  high when level >= AFULL.

Function
REQ-012 SHALL accept a word when din.valid && din.ready; din.ready = (level != DEPTH), with no combinational path from dout.ready.
REQ-013 SHALL keep (CW+1)-bit read/write pointers (CW = $clog2(DEPTH)), wrapping modulo 2*DEPTH; level = wptr - rptr.
REQ-014 SHALL count stored eot words in eot_cnt (width CW+1): +1 on write of an eot word, -1 on read of an eot word, net 0 when both happen in one cycle.
REQ-015 SHALL assert release = ~empty && (THRESHOLD == 0 || level >= THRESHOLD || eot_cnt != 0), so a partial burst ending in eot drains below threshold.
REQ-016 SHALL NOT clear storage or pointers on eot; eot is data only.
REQ-017 REGOUT=0: dout.valid = release; dout.data = head word; read on release && dout.ready; a word written in cycle N is presentable in cycle N+1.
REQ-018 REGOUT=1: output register loads head word and valid when (!dout.valid || dout.ready); read on release && that load condition; a word written in cycle N is presentable in cycle N+2.
REQ-019 SHALL hold dout.data and dout.valid stable while dout.valid && !dout.ready.
REQ-020 Full with simultaneous read: write refused in that cycle (din.ready already low); level goes DEPTH-1 next cycle.
REQ-021 Empty with simultaneous write: no read that cycle; level goes to 1.
REQ-022 level and almost_full SHALL reflect storage only, excluding the REGOUT register.
REQ-023 SHALL flag THRESHOLD > DEPTH, AFULL outside 1..DEPTH, or non-power-of-two DEPTH with an elaboration-time error.

Reset
REQ-024 On rst: pointers, level, eot_cnt = 0; dout.valid = 0; REGOUT register data = 0; almost_full = 0; din.ready = 1 on the first cycle after reset.
REQ-025 rst mid-transfer SHALL discard all stored words and any registered output word in the same cycle; RAM contents are not cleared.

Structure
REQ-026 The pointer/level width function and the eot-split word struct (eot, data) SHALL live in shared package fifo_pkg.
REQ-027 Storage SHALL be a sub-module fifo_ram: simple dual-port, one synchronous write port, one asynchronous read port, DEPTH x DIN, no reset.

Verification
REQ-028 DEPTH=8, THRESHOLD=0, REGOUT=0: write 8 words, dout.ready=0 -> level=8, din.ready=0, almost_full=1; then drain -> words out in order, level returns to 0.
REQ-029 DEPTH=8, THRESHOLD=4: write 3 words without eot -> dout.valid stays 0; 4th word -> dout.valid=1 the next cycle.
REQ-030 THRESHOLD=4: write 2 words, the 2nd with eot -> both released, eot_cnt returns to 0 after the 2nd read.
REQ-031 REGOUT=1, full FIFO, dout.ready toggling 1/0 every cycle -> no word lost or duplicated; data stable while stalled.
REQ-032 Write and read in the same cycle at level=8 (full) and at level=0 (empty) -> behaviour per REQ-020/REQ-021.
REQ-033 Assert rst with 5 words stored and dout.valid=1 -> next cycle level=0, dout.valid=0, din.ready=1.
